// File: rtl/next_kbd_pkg.sv
// Shared constants, FSM state and event payload types for the NeXT keyboard link.
// Used by the device model (next_kbd_device) and by the matching host block.
package next_kbd_pkg;

    localparam int unsigned QUERY_BITS = 8;
    localparam int unsigned CMD_BITS   = 21;
    localparam int unsigned REPLY_BITS = 20;
    localparam int unsigned EV_W       = 16;

    localparam logic [QUERY_BITS-1:0] QUERY_KB      = 8'h08;
    localparam logic [QUERY_BITS-1:0] QUERY_MS      = 8'h88;
    localparam logic [CMD_BITS-1:0]   CMD_RESET     = 21'h1EFC00;
    localparam logic [11:0]           CMD_LED_PFX   = 12'h00E;
    localparam logic [REPLY_BITS-1:0] RESP_READY    = 20'h80300;
    localparam logic [2:0]            RESP_DATA_TAG = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_START,
        ST_RX_BITS,
        ST_DECODE,
        ST_TURN,
        ST_TX
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_KB,
        SRC_MS
    } src_t;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
    } ev_data_t;

    // Data reply word: {0, hi, tag, lo}, sent LSB first.
    function automatic logic [REPLY_BITS-1:0] pack_reply(input ev_data_t d);
        return {1'b0, d.hi, RESP_DATA_TAG, d.lo};
    endfunction

endpackage

// File: rtl/next_kbd_device_if.sv
// Serial line, key/mouse event and status signals of the NeXT keyboard device.
// master = host/event source side, slave = device side.
interface next_kbd_device_if;
    import next_kbd_pkg::*;

    logic       kb_in;
    logic       kb_out;
    logic       kb_ev_valid;
    ev_data_t   kb_ev_data;
    logic       kb_ev_ready;
    logic       ms_ev_valid;
    ev_data_t   ms_ev_data;
    logic       ms_ev_ready;
    logic [1:0] led_out;
    logic       led_valid;
    logic       online;

    modport master (
        output kb_in, kb_ev_valid, kb_ev_data, ms_ev_valid, ms_ev_data,
        input  kb_out, kb_ev_ready, ms_ev_ready, led_out, led_valid, online
    );

    modport slave (
        input  kb_in, kb_ev_valid, kb_ev_data, ms_ev_valid, ms_ev_data,
        output kb_out, kb_ev_ready, ms_ev_ready, led_out, led_valid, online
    );

endinterface

// File: rtl/next_kbd_bit_timer.sv
// Free-running bit-period counter; load restarts the period, strobes fire at
// mid-bit (half_tick_c) and at the end of the period (bit_tick_c).
module next_kbd_bit_timer #(
    parameter int unsigned BIT_CLKS = 265
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic half_tick_c,
    output logic bit_tick_c
);

    localparam int unsigned CNT_W = $clog2(BIT_CLKS);
    localparam int unsigned HALF  = BIT_CLKS / 2;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign half_tick_c = (cnt_q == CNT_W'(HALF - 1));
    assign bit_tick_c  = (cnt_q == CNT_W'(BIT_CLKS - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (load || bit_tick_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/next_kbd_device.sv
// NeXT keyboard/mouse device end: receives host queries/commands on kb_in, replies on kb_out.
// Optional macro NEXT_KBD_START_CHECK_EN: reject start bits that are high again at mid-bit.
module next_kbd_device
    import next_kbd_pkg::*;
#(
    parameter int unsigned BIT_CLKS        = 265,
    parameter int unsigned TURNAROUND_BITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    next_kbd_device_if.slave bus
);

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned TURN_HALVES = TURNAROUND_BITS + 1;

    state_t                  state_q, state_d;
    logic [2:0]              sync_q, sync_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [CMD_BITS-1:0]     shreg_q, shreg_d;
    logic                    is_query_q, is_query_d;
    logic                    query_ms_q, query_ms_d;
    logic [REPLY_BITS-1:0]   reply_q, reply_d;
    src_t                    src_q, src_d;
    logic                    kb_out_q, kb_out_d;
    logic                    kb_rdy_q, kb_rdy_d;
    logic                    ms_rdy_q, ms_rdy_d;
    logic [1:0]              led_q, led_d;
    logic                    led_valid_q, led_valid_d;
    logic                    online_q, online_d;

    logic                    load_c;
    logic                    half_tick_c;
    logic                    bit_tick_c;
    logic                    line_c;
    logic                    fall_c;
    logic [CMD_BITS-1:0]     shift_c;
    logic [CNT_W-1:0]        bits_c;
    logic                    query8_c;
    logic                    full_c;

    next_kbd_bit_timer #(.BIT_CLKS(BIT_CLKS)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .load        (load_c),
        .half_tick_c (half_tick_c),
        .bit_tick_c  (bit_tick_c)
    );

    // Synchronised line, falling-edge detect and receive shift helpers.
    assign sync_d   = {sync_q[1:0], bus.kb_in};
    assign line_c   = sync_q[1];
    assign fall_c   = sync_q[2] & ~sync_q[1];
    assign shift_c  = {shreg_q[CMD_BITS-2:0], line_c};
    assign bits_c   = bit_cnt_q + CNT_W'(1);
    assign query8_c = (bits_c == CNT_W'(QUERY_BITS)) &&
                      ((shift_c[QUERY_BITS-1:0] == QUERY_KB) ||
                       (shift_c[QUERY_BITS-1:0] == QUERY_MS));
    assign full_c   = (bits_c == CNT_W'(CMD_BITS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fall_c) state_d = ST_RX_START;
            end
            ST_RX_START: begin
                if (half_tick_c) begin
`ifdef NEXT_KBD_START_CHECK_EN
                    state_d = line_c ? ST_IDLE : ST_RX_BITS;
`else
                    state_d = ST_RX_BITS;
`endif
                end
            end
            ST_RX_BITS: begin
                if (bit_tick_c && (query8_c || full_c)) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = (is_query_q && online_q) ? ST_TURN : ST_IDLE;
            end
            ST_TURN: begin
                if (half_tick_c && (bit_cnt_q == CNT_W'(TURN_HALVES - 1))) state_d = ST_TX;
            end
            ST_TX: begin
                if (bit_tick_c && (bit_cnt_q == CNT_W'(REPLY_BITS))) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_c      = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        is_query_d  = is_query_q;
        query_ms_d  = query_ms_q;
        reply_d     = reply_q;
        src_d       = src_q;
        kb_out_d    = kb_out_q;
        kb_rdy_d    = 1'b0;
        ms_rdy_d    = 1'b0;
        led_d       = led_q;
        led_valid_d = 1'b0;
        online_d    = online_q;
        case (state_q)
            ST_IDLE: begin
                if (fall_c) begin
                    load_c     = 1'b1;
                    bit_cnt_d  = '0;
                    shreg_d    = '0;
                    is_query_d = 1'b0;
                end
            end
            ST_RX_START: begin
                if (half_tick_c) load_c = 1'b1;
            end
            ST_RX_BITS: begin
                if (bit_tick_c) begin
                    shreg_d    = shift_c;
                    bit_cnt_d  = bits_c;
                    is_query_d = query8_c;
                    query_ms_d = shift_c[QUERY_BITS-1];
                end
            end
            ST_DECODE: begin
                bit_cnt_d = '0;
                if (!is_query_q) begin
                    if (shreg_q == CMD_RESET) begin
                        online_d = 1'b1;
                    end else if (shreg_q[CMD_BITS-1:9] == CMD_LED_PFX) begin
                        led_d       = shreg_q[8:7];
                        led_valid_d = 1'b1;
                    end
                end
            end
            ST_TURN: begin
                // Turnaround ends on the (TURNAROUND_BITS+1)th mid-bit strobe after the last sample.
                if (half_tick_c) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(TURN_HALVES - 1)) begin
                        load_c    = 1'b1;
                        bit_cnt_d = '0;
                        kb_out_d  = 1'b0;
                        if (!query_ms_q && bus.kb_ev_valid) begin
                            reply_d = pack_reply(bus.kb_ev_data);
                            src_d   = SRC_KB;
                        end else if (query_ms_q && bus.ms_ev_valid) begin
                            reply_d = pack_reply(bus.ms_ev_data);
                            src_d   = SRC_MS;
                        end else begin
                            reply_d = RESP_READY;
                            src_d   = SRC_NONE;
                        end
                    end
                end
            end
            ST_TX: begin
                if (bit_tick_c) begin
                    if (bit_cnt_q == CNT_W'(REPLY_BITS)) begin
                        kb_out_d = 1'b1;
                        kb_rdy_d = (src_q == SRC_KB);
                        ms_rdy_d = (src_q == SRC_MS);
                        src_d    = SRC_NONE;
                    end else begin
                        kb_out_d  = reply_q[0];
                        reply_d   = {1'b0, reply_q[REPLY_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= 3'b111;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            is_query_q  <= 1'b0;
            query_ms_q  <= 1'b0;
            reply_q     <= '0;
            src_q       <= SRC_NONE;
            kb_out_q    <= 1'b1;
            kb_rdy_q    <= 1'b0;
            ms_rdy_q    <= 1'b0;
            led_q       <= 2'b00;
            led_valid_q <= 1'b0;
            online_q    <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            is_query_q  <= is_query_d;
            query_ms_q  <= query_ms_d;
            reply_q     <= reply_d;
            src_q       <= src_d;
            kb_out_q    <= kb_out_d;
            kb_rdy_q    <= kb_rdy_d;
            ms_rdy_q    <= ms_rdy_d;
            led_q       <= led_d;
            led_valid_q <= led_valid_d;
            online_q    <= online_d;
        end
    end

    assign bus.kb_out      = kb_out_q;
    assign bus.kb_ev_ready = kb_rdy_q;
    assign bus.ms_ev_ready = ms_rdy_q;
    assign bus.led_out     = led_q;
    assign bus.led_valid   = led_valid_q;
    assign bus.online      = online_q;

endmodule

// File: tb/tb_next_kbd_device.sv
// Directed bench for next_kbd_device: host frames on kb_in, reply words decoded from kb_out.
// Bit period shortened to 101 clocks (odd, so the half-bit is 50) to keep the run short.
module tb_next_kbd_device;
    import next_kbd_pkg::*;

    localparam int unsigned B = 101;
    localparam int unsigned H = B / 2;
    // Query end -> first low kb_out negedge: 2 sync + 1 edge detect + 2*H + 2*B.
    localparam int unsigned TURN_EXP = 305;

    logic clk = 1'b0;
    logic rst;

    next_kbd_device_if bus();

    next_kbd_device #(.BIT_CLKS(B), .TURNAROUND_BITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int kb_rdy_cnt = 0;
    int ms_rdy_cnt = 0;
    int led_cnt    = 0;
    int low_cnt    = 0;

    always @(negedge clk) begin
        if (bus.kb_ev_ready === 1'b1) kb_rdy_cnt++;
        if (bus.ms_ev_ready === 1'b1) ms_rdy_cnt++;
        if (bus.led_valid === 1'b1)   led_cnt++;
        if (bus.kb_out !== 1'b1)      low_cnt++;
    end

    typedef struct {
        logic        kb_v;
        logic [15:0] kb_d;
        logic        ms_v;
        logic [15:0] ms_d;
        logic [7:0]  query;
        logic [19:0] exp_r;
        int          exp_kb;
        int          exp_ms;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_bits(input int n);
        repeat (n * B) @(negedge clk);
    endtask

    // Start bit, nbits payload MSB first, then line back high.
    task automatic send_frame(input logic [20:0] v, input int nbits);
        @(negedge clk);
        bus.kb_in = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.kb_in = v[i];
            repeat (B) @(negedge clk);
        end
        bus.kb_in = 1'b1;
    endtask

    task automatic query_reply(input string tag, input logic [7:0] q, input logic [19:0] exp_r,
                               input int exp_kb, input int exp_ms);
        int kb0;
        int ms0;
        int n;
        logic [19:0] r;
        kb0 = kb_rdy_cnt;
        ms0 = ms_rdy_cnt;
        n   = 0;
        r   = '0;
        send_frame({13'b0, q}, 8);
        while (bus.kb_out !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n < TURN_EXP - 1 || n > TURN_EXP + 1) begin
            n_fail++;
            $display("FAIL %s turnaround: got %0d cycles, expected %0d", tag, n, TURN_EXP);
        end
        repeat (H) @(negedge clk);
        check({tag, " start bit"}, 32'(bus.kb_out), 32'h0);
        for (int k = 0; k < 20; k++) begin
            repeat (B) @(negedge clk);
            r[k] = bus.kb_out;
        end
        check({tag, " reply word"}, 32'(r), 32'(exp_r));
        repeat (B) @(negedge clk);
        check({tag, " line idle"}, 32'(bus.kb_out), 32'h1);
        check({tag, " kb_ev_ready pulses"}, 32'(kb_rdy_cnt - kb0), 32'(exp_kb));
        check({tag, " ms_ev_ready pulses"}, 32'(ms_rdy_cnt - ms0), 32'(exp_ms));
        idle_bits(1);
    endtask

    initial begin
        int low0;
        int led0;
        int kb0;
        int n;

        vecs[0] = '{1'b0, 16'h0000, 1'b0, 16'h0000, QUERY_KB, 20'h80300, 0, 0};
        vecs[1] = '{1'b1, 16'hA55A, 1'b0, 16'h0000, QUERY_KB, 20'h52A5A, 1, 0};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 16'h0102, QUERY_KB, 20'h80300, 0, 0};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 16'h0102, QUERY_MS, 20'h00A02, 0, 1};
        vecs[4] = '{1'b1, 16'h1234, 1'b1, 16'h5678, QUERY_MS, 20'h2B278, 0, 1};
        vecs[5] = '{1'b1, 16'h1234, 1'b1, 16'h5678, QUERY_KB, 20'h09234, 1, 0};

        rst             = 1'b1;
        bus.kb_in       = 1'b1;
        bus.kb_ev_valid = 1'b0;
        bus.kb_ev_data  = '0;
        bus.ms_ev_valid = 1'b0;
        bus.ms_ev_data  = '0;
        repeat (5) @(negedge clk);
        check("reset kb_out", 32'(bus.kb_out), 32'h1);
        check("reset online", 32'(bus.online), 32'h0);
        check("reset led_out", 32'(bus.led_out), 32'h0);
        check("reset led_valid", 32'(bus.led_valid), 32'h0);
        check("reset kb_ev_ready", 32'(bus.kb_ev_ready), 32'h0);
        check("reset ms_ev_ready", 32'(bus.ms_ev_ready), 32'h0);
        rst = 1'b0;
        idle_bits(1);

        // Query while offline: silence.
        low0 = low_cnt;
        send_frame({13'b0, QUERY_KB}, 8);
        idle_bits(40);
        check("offline query kb_out activity", 32'(low_cnt - low0), 32'h0);
        check("offline query online", 32'(bus.online), 32'h0);

        // Reset command brings the device online without a reply.
        low0 = low_cnt;
        send_frame(CMD_RESET, 21);
        idle_bits(2);
        check("reset cmd online", 32'(bus.online), 32'h1);
        check("reset cmd kb_out activity", 32'(low_cnt - low0), 32'h0);

        // LED commands; a wrong prefix must be ignored.
        low0 = low_cnt;
        led0 = led_cnt;
        send_frame(21'h001D80, 21);
        idle_bits(2);
        check("led 11 value", 32'(bus.led_out), 32'h3);
        check("led 11 pulses", 32'(led_cnt - led0), 32'h1);
        led0 = led_cnt;
        send_frame(21'h001C80, 21);
        idle_bits(2);
        check("led 01 value", 32'(bus.led_out), 32'h1);
        check("led 01 pulses", 32'(led_cnt - led0), 32'h1);
        led0 = led_cnt;
        send_frame(21'h001F80, 21);
        idle_bits(2);
        check("bad led prefix value", 32'(bus.led_out), 32'h1);
        check("bad led prefix pulses", 32'(led_cnt - led0), 32'h0);
        check("led cmds kb_out activity", 32'(low_cnt - low0), 32'h0);

        for (int i = 0; i < 6; i++) begin
            bus.kb_ev_valid = vecs[i].kb_v;
            bus.kb_ev_data  = vecs[i].kb_d;
            bus.ms_ev_valid = vecs[i].ms_v;
            bus.ms_ev_data  = vecs[i].ms_d;
            query_reply($sformatf("vec%0d", i), vecs[i].query, vecs[i].exp_r,
                        vecs[i].exp_kb, vecs[i].exp_ms);
            bus.kb_ev_valid = 1'b0;
            bus.ms_ev_valid = 1'b0;
        end

        // Reset in the middle of a data reply.
        bus.kb_ev_valid = 1'b1;
        bus.kb_ev_data  = 16'hA55A;
        send_frame({13'b0, QUERY_KB}, 8);
        n = 0;
        while (bus.kb_out !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("mid-tx reply started", 32'(bus.kb_out), 32'h0);
        repeat (5 * B) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid-tx rst kb_out", 32'(bus.kb_out), 32'h1);
        check("mid-tx rst online", 32'(bus.online), 32'h0);
        rst  = 1'b0;
        kb0  = kb_rdy_cnt;
        low0 = low_cnt;
        idle_bits(25);
        check("mid-tx rst kb_ev_ready", 32'(kb_rdy_cnt - kb0), 32'h0);
        check("mid-tx rst kb_out activity", 32'(low_cnt - low0), 32'h0);
        bus.kb_ev_valid = 1'b0;

        // Two-cycle low glitch on kb_in.
        low0 = low_cnt;
        led0 = led_cnt;
        @(negedge clk);
        bus.kb_in = 1'b0;
        repeat (2) @(negedge clk);
        bus.kb_in = 1'b1;
`ifdef NEXT_KBD_START_CHECK_EN
        idle_bits(2);
`else
        idle_bits(23);
`endif
        check("glitch online", 32'(bus.online), 32'h0);
        check("glitch kb_out activity", 32'(low_cnt - low0), 32'h0);
        check("glitch led pulses", 32'(led_cnt - led0), 32'h0);
        send_frame(CMD_RESET, 21);
        idle_bits(2);
        check("post-glitch reset cmd online", 32'(bus.online), 32'h1);
        query_reply("post-glitch", QUERY_KB, 20'h80300, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
